// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU load/store channel and its data memory
// responder.
//   WORD_W / ADDR_W : data and address widths of the channel
//   state_e         : responder FSM states
//   mem_req_t       : captured request (also used by the CPU-side initiator)
//   addr_in_range   : full-width address check against the memory depth
package mem_if_pkg;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Compares the whole address, so out-of-range words never alias onto
    // low addresses.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned depth);
        return 32'(addr) < depth;
    endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the CPU (master) and the data memory
// responder (slave). Both directions use a valid/ready handshake.
//   req_valid/req_ready            : request handshake
//   req_write/req_addr/req_wdata   : request payload
//   rsp_valid/rsp_ready            : response handshake
//   rsp_rdata/rsp_err/rsp_write    : response payload
interface data_mem_responder_if;
    import mem_if_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
    );
endinterface

// File: rtl/data_mem_array.sv
// DEPTH x WORD_W register array.
//   clk, rst : clock, synchronous active-high clear of every word
//   we       : write enable (ignored for out-of-range addresses)
//   waddr    : write address, wdata : write data
//   raddr    : combinational read address, rdata : read data (0 if out of range)
module data_mem_array
    import mem_if_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WORD_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (we && addr_in_range(waddr, DEPTH)) begin
            mem[waddr[IDX_W-1:0]] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (addr_in_range(raddr, DEPTH)) begin
            rdata = mem[raddr[IDX_W-1:0]];
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU load/store channel. Accepts one request at a
// time, waits LATENCY cycles, then commits the store or reads the word and
// presents a registered response until the CPU takes it.
//   clk, rst : clock, synchronous active-high reset (also clears memory)
//   bus      : slave side of data_mem_responder_if
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_req_t          req_q, cur_req;
    logic              accept, commit, in_rng;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] rsp_rdata_q;
    logic              rsp_err_q, rsp_write_q;

    // With LATENCY=0 the commit happens on the acceptance edge itself, so the
    // live bus payload is used while still in IDLE.
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req = '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    assign in_rng = addr_in_range(cur_req.addr, DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid && !rst) begin
                    accept = 1'b1;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = 4'(cnt_q - 4'd1);
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Single point where a transaction takes effect: entry into RESP.
    assign commit = (state_d == RESP) && (state_q != RESP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) req_q <= cur_req;
            if (commit) begin
                rsp_write_q <= cur_req.write;
                rsp_err_q   <= !in_rng;
                rsp_rdata_q <= (!cur_req.write && in_rng) ? mem_rdata : '0;
            end
        end
    end

    data_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && cur_req.write && in_rng),
        .waddr (cur_req.addr),
        .wdata (cur_req.wdata),
        .raddr (cur_req.addr),
        .rdata (mem_rdata)
    );

    // req_ready is held low through the reset cycle itself.
    assign bus.req_ready = (state_q == IDLE) && !rst;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_write = rsp_write_q;
endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acc_cyc;

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;

    // index 0: LATENCY=2 instance, index 1: LATENCY=0 instance (rsp_ready tied 1)
    logic [1:0] rv, rw, rr;
    logic [15:0] ra [2];
    logic [15:0] rwd [2];
    logic [1:0] o_rdy, o_vld, o_err, o_wr;
    logic [15:0] o_rd [2];

    data_mem_responder_if b0 ();
    data_mem_responder_if b1 ();

    assign b0.req_valid = rv[0];  assign b1.req_valid = rv[1];
    assign b0.req_write = rw[0];  assign b1.req_write = rw[1];
    assign b0.req_addr  = ra[0];  assign b1.req_addr  = ra[1];
    assign b0.req_wdata = rwd[0]; assign b1.req_wdata = rwd[1];
    assign b0.rsp_ready = rr[0];  assign b1.rsp_ready = rr[1];
    assign o_rdy[0] = b0.req_ready; assign o_rdy[1] = b1.req_ready;
    assign o_vld[0] = b0.rsp_valid; assign o_vld[1] = b1.rsp_valid;
    assign o_err[0] = b0.rsp_err;   assign o_err[1] = b1.rsp_err;
    assign o_wr[0]  = b0.rsp_write; assign o_wr[1]  = b1.rsp_write;
    assign o_rd[0]  = b0.rsp_rdata; assign o_rd[1]  = b1.rsp_rdata;

    data_mem_responder #(.DEPTH(16), .LATENCY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    data_mem_responder #(.DEPTH(16), .LATENCY(0)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered and left at a negedge. hold>0 keeps rsp_ready low that many
    // cycles; poke fires an intruding SW 5<-DEAD in the middle of the hold.
    task automatic transact(input int s, input logic w, input logic [15:0] a,
                            input logic [15:0] wd, input logic [15:0] exp_rd,
                            input logic exp_err, input int hold, input logic poke,
                            input string nm);
        int k;
        rw[s] = w; ra[s] = a; rwd[s] = wd; rv[s] = 1'b1;
        k = 0;
        while (!o_rdy[s] && k < 20) begin @(negedge clk); k++; end
        chk({nm, " req_ready"}, 32'(o_rdy[s]), 32'd1);
        @(posedge clk);
        acc_cyc = cyc;
        #1;
        rv[s] = 1'b0; rw[s] = ~w; ra[s] = 16'h5A5A; rwd[s] = 16'hC3C3;
        k = 0;
        do begin @(negedge clk); k++; end while (!o_vld[s] && k < 40);
        chk({nm, " latency"}, 32'(k), (s == 0) ? 32'd3 : 32'd1);
        chk({nm, " rdata"}, 32'(o_rd[s]), 32'(exp_rd));
        chk({nm, " err"}, 32'(o_err[s]), 32'(exp_err));
        chk({nm, " write"}, 32'(o_wr[s]), 32'(w));
        for (int h = 0; h < hold; h++) begin
            chk({nm, " hold"}, {o_vld[s], o_rdy[s], o_err[s], 13'd0, o_rd[s]},
                {1'b1, 1'b0, exp_err, 13'd0, exp_rd});
            if (poke && h == 2) begin
                rv[s] = 1'b1; rw[s] = 1'b1; ra[s] = 16'd5; rwd[s] = 16'hDEAD;
            end else begin
                rv[s] = 1'b0;
            end
            @(negedge clk);
        end
        rv[s] = 1'b0;
        if (s == 0) begin
            rr[0] = 1'b1;
            @(posedge clk);
            #1 rr[0] = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        err;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int prev;
        tbl[0] = '{1'b1, 16'd3,      16'h00A5, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 16'd3,      16'h0000, 16'h00A5, 1'b0};
        tbl[2] = '{1'b1, 16'd16,     16'hFFFF, 16'h0000, 1'b1};
        tbl[3] = '{1'b0, 16'd0,      16'h0000, 16'h0000, 1'b0};
        tbl[4] = '{1'b0, 16'd16,     16'h0000, 16'h0000, 1'b1};
        tbl[5] = '{1'b1, 16'd5,      16'h1234, 16'h0000, 1'b0};
        tbl[6] = '{1'b1, 16'd15,     16'hBEEF, 16'h0000, 1'b0};
        tbl[7] = '{1'b0, 16'd15,     16'h0000, 16'hBEEF, 1'b0};
        tbl[8] = '{1'b1, 16'hFFFF,   16'h1111, 16'h0000, 1'b1};
        tbl[9] = '{1'b0, 16'hFFFF,   16'h0000, 16'h0000, 1'b1};

        rst = 1'b1; rv = '0; rw = '0; rr = 2'b10;
        ra[0] = '0; ra[1] = '0; rwd[0] = '0; rwd[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", {30'd0, o_rdy}, 32'd0);
        chk("reset rsp_valid", {30'd0, o_vld}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post-reset req_ready", {30'd0, o_rdy}, 32'd3);
        chk("post-reset rsp regs", {o_vld[0], o_err[0], o_wr[0], 13'd0, o_rd[0]}, 32'd0);
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            transact(0, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err, 0, 1'b0, "vec");

        // backpressure with an intruding request that must be ignored
        transact(0, 1'b0, 16'd5, 16'h0, 16'h1234, 1'b0, 7, 1'b1, "bp lw5");
        transact(0, 1'b0, 16'd5, 16'h0, 16'h1234, 1'b0, 0, 1'b0, "bp readback");

        // LATENCY=0 streaming, one acceptance every 2 cycles
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            transact(1, 1'b1, 16'(i), 16'(i * 3), 16'h0, 1'b0, 0, 1'b0, "b2b sw");
            if (i > 0) chk("b2b spacing", 32'(acc_cyc - prev), 32'd2);
            prev = acc_cyc;
        end
        for (int i = 0; i < 8; i++)
            transact(1, 1'b0, 16'(i), 16'h0, 16'(i * 3), 1'b0, 0, 1'b0, "b2b lw");

        // reset while a store sits in WAIT
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 16'd2; rwd[0] = 16'h0077;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 chk("midop reset req_ready", {30'd0, o_rdy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("midop no rsp_valid", 32'(o_vld[0]), 32'd0);
            @(negedge clk);
        end
        transact(0, 1'b0, 16'd2, 16'h0, 16'h0000, 1'b0, 0, 1'b0, "midop lw2");

        // every word cleared by reset
        for (int i = 0; i < 16; i++)
            transact(0, 1'b0, 16'(i), 16'h0, 16'h0000, 1'b0, 0, 1'b0, "clear lw");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
